// File: rtl/des_ks_pkg.sv
// Shared DES key-schedule tables and helpers: per-round shift amounts, PC-1/PC-2
// permutations, and the cumulative rotation used for the decrypt start point.
package des_ks_pkg;

  localparam int RND_W = 4;

  typedef enum logic {
    IDLE,
    RUN
  } ks_state_t;

  localparam logic [1:0] SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Tables hold 1-based DES bit numbers; bit 1 is the MSB of the source vector.
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] pc1(input logic [63:0] key);
    logic [55:0] r;
    logic [5:0]  src;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      src = 6'(64 - PC1_TAB[i]);
      r[6'(55 - i)] = key[src];
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    logic [5:0]  src;
    r = '0;
    for (int i = 0; i < 48; i++) begin
      src = 6'(56 - PC2_TAB[i]);
      r[6'(47 - i)] = cd[src];
    end
    return r;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
    return (x << n) | (x >> (28 - n));
  endfunction

  function automatic logic [55:0] rotl_cd(input logic [55:0] cd, input int n);
    return {rotl28(cd[55:28], n), rotl28(cd[27:0], n)};
  endfunction

  function automatic int rot_total(input int rounds);
    int sum;
    sum = 0;
    for (int i = 0; i < rounds; i++) sum += int'(SHIFT[4'(i)]);
    return sum % 28;
  endfunction

endpackage

// File: rtl/des_cd_rot.sv
// Combinational rotate of the C and D halves (28 bits each) by 0, 1 or 2 places,
// toward the MSB (left) or the LSB (right).
module des_cd_rot
  import des_ks_pkg::*;
(
  input  logic [55:0] cd_in,
  input  logic [1:0]  amt,
  input  logic        dir_right,
  output logic [55:0] cd_out
);

  logic [27:0] c;
  logic [27:0] d;

  always_comb begin
    c      = cd_in[55:28];
    d      = cd_in[27:0];
    cd_out = cd_in;
    if (!dir_right) begin
      case (amt)
        2'd1:    cd_out = {c[26:0], c[27], d[26:0], d[27]};
        2'd2:    cd_out = {c[25:0], c[27:26], d[25:0], d[27:26]};
        default: cd_out = cd_in;
      endcase
    end else begin
      case (amt)
        2'd1:    cd_out = {c[0], c[27:1], d[0], d[27:1]};
        2'd2:    cd_out = {c[1:0], c[27:2], d[1:0], d[27:2]};
        default: cd_out = cd_in;
      endcase
    end
  end

endmodule

// File: rtl/des_key_sched.sv
// Sequential DES key schedule streaming one PC-2 subkey per cycle in encrypt or decrypt order.
// Optional key byte odd-parity check is enabled by defining PARITY_CHECK_EN.
module des_key_sched
  import des_ks_pkg::*;
#(
  parameter int ROUNDS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [63:0]      key_in,
  input  logic             key_mode,
  input  logic             abort,
  output logic             sk_valid,
  input  logic             sk_ready,
  output logic [47:0]      sk_data,
  output logic [RND_W-1:0] sk_round,
  output logic             sk_last,
  output logic             parity_err
);

  localparam logic [RND_W-1:0] LAST_IDX = RND_W'(ROUNDS - 1);
  localparam int               TOT      = rot_total(ROUNDS);

  ks_state_t        state_q, state_d;
  logic [55:0]      cd_q, cd_d, rot_out, pc1_key, start_cd;
  logic             mode_q, mode_d;
  logic [47:0]      data_d;
  logic [RND_W-1:0] round_d, nxt_idx, shf_idx;
  logic             last_d, accept, handshake, key_ok;

  assign key_ready = (state_q == IDLE);
  assign sk_valid  = (state_q == RUN);
  assign accept    = key_valid && key_ready;
  assign handshake = sk_valid && sk_ready;

  // Decrypt walks backwards: rotate right by the shift of the round just emitted.
  assign nxt_idx = mode_q ? (sk_round - RND_W'(1)) : (sk_round + RND_W'(1));
  assign shf_idx = mode_q ? sk_round : nxt_idx;

  assign pc1_key  = pc1(key_in);
  assign start_cd = key_mode ? rotl_cd(pc1_key, TOT) : rotl_cd(pc1_key, int'(SHIFT[0]));

  des_cd_rot u_rot (
    .cd_in     (cd_q),
    .amt       (SHIFT[shf_idx]),
    .dir_right (mode_q),
    .cd_out    (rot_out)
  );

`ifdef PARITY_CHECK_EN
  logic [7:0] byte_odd;

  always_comb begin
    byte_odd = '0;
    for (int i = 0; i < 8; i++) byte_odd[i] = ^key_in[8*i +: 8];
    key_ok = &byte_odd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err <= 1'b0;
    else        parity_err <= accept && !key_ok;
  end
`else
  assign key_ok     = 1'b1;
  assign parity_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    mode_d  = mode_q;
    data_d  = sk_data;
    round_d = sk_round;
    last_d  = sk_last;
    case (state_q)
      IDLE: begin
        if (accept && key_ok) begin
          state_d = RUN;
          mode_d  = key_mode;
          cd_d    = start_cd;
          data_d  = pc2(start_cd);
          round_d = key_mode ? LAST_IDX : '0;
          last_d  = (ROUNDS == 1);
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end else if (handshake) begin
          if (sk_last) begin
            state_d = IDLE;
            last_d  = 1'b0;
          end else begin
            cd_d    = rot_out;
            data_d  = pc2(rot_out);
            round_d = nxt_idx;
            last_d  = mode_q ? (nxt_idx == '0) : (nxt_idx == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cd_q     <= '0;
      mode_q   <= 1'b0;
      sk_data  <= '0;
      sk_round <= '0;
      sk_last  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cd_q     <= cd_d;
      mode_q   <= mode_d;
      sk_data  <= data_d;
      sk_round <= round_d;
      sk_last  <= last_d;
    end
  end

endmodule
